// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - opcode encodings, FSM state type and helpers for the iterative MDU
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/response bundle between the execute stage and the MDU
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, valid, result
    );
endinterface

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - restoring divide datapath, one quotient bit per step on magnitudes
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // quot starts as the dividend and fills with quotient bits from the bottom
    assign shifted = {rem, quot[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot      <= '0;
            rem       <= '0;
            divisor_q <= '0;
        end else if (load) begin
            quot      <= dividend;
            rem       <= '0;
            divisor_q <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem  <= diff[WIDTH-1:0];
                quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
                rem  <= shifted[WIDTH-1:0];
                quot <= {quot[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative M-extension multiply/divide unit; MDU_FAST_MUL_EN selects a single-cycle multiply
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    mdu_iter_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_e state_q, state_d;

    logic [2:0]         op_q;
    logic               neg_q, rneg_q, bypass_q;
    logic [WIDTH-1:0]   absa_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   result_q;

    logic               accept, step_en, finish;
    logic               a_signed, b_signed, sa, sb, div_zero, ovf;
    logic [WIDTH-1:0]   abs_a, abs_b, spec_val, final_val;
    logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     mul_sum;

    assign accept = (state_q == IDLE) && bus.start && !bus.flush;

    assign a_signed = (bus.op == MDU_MULH) || (bus.op == MDU_MULHSU) ||
                      (bus.op == MDU_DIV)  || (bus.op == MDU_REM);
    assign b_signed = (bus.op == MDU_MULH) || (bus.op == MDU_DIV) || (bus.op == MDU_REM);
    assign sa       = a_signed && bus.a[WIDTH-1];
    assign sb       = b_signed && bus.b[WIDTH-1];
    assign abs_a    = sa ? -bus.a : bus.a;
    assign abs_b    = sb ? -bus.b : bus.b;

    assign div_zero = is_div(bus.op) && (bus.b == '0);
    assign ovf      = ((bus.op == MDU_DIV) || (bus.op == MDU_REM)) &&
                      (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    // op[1] separates the remainder ops from the quotient ops
    assign spec_val = div_zero ? (bus.op[1] ? bus.a : '1)
                               : (bus.op[1] ? '0 : bus.a);

    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? absa_q : '0)};

    assign prod_fix = neg_q  ? -prod_q : prod_q;
    assign quot_fix = neg_q  ? -quot   : quot;
    assign rem_fix  = rneg_q ? -rem    : rem;

    // bypassed operations already hold their signed final value in prod_q
    always_comb begin
        final_val = '0;
        if (bypass_q) begin
            if ((op_q == MDU_MUL) || is_div(op_q))
                final_val = prod_q[WIDTH-1:0];
            else
                final_val = prod_q[2*WIDTH-1:WIDTH];
        end else if (is_div(op_q)) begin
            final_val = op_q[1] ? rem_fix : quot_fix;
        end else if (op_q == MDU_MUL) begin
            final_val = prod_fix[WIDTH-1:0];
        end else begin
            final_val = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        step_en = 1'b0;
        finish  = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) state_d = CALC;
                CALC: begin
                    if (bypass_q || (cnt_q == CW'(WIDTH))) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end else begin
                        step_en = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bypass_q <= 1'b0;
            absa_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= bus.op;
                absa_q   <= abs_a;
                neg_q    <= sa ^ sb;
                rneg_q   <= sa;
                cnt_q    <= '0;
                bypass_q <= div_zero || ovf;
                prod_q   <= (div_zero || ovf) ? {{WIDTH{1'b0}}, spec_val} : {{WIDTH{1'b0}}, abs_b};
`ifdef MDU_FAST_MUL_EN
                if (!is_div(bus.op)) begin
                    bypass_q <= 1'b1;
                    prod_q   <= (a_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a}) *
                                (b_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b});
                end
`endif
            end else if (step_en) begin
                cnt_q <= cnt_q + CW'(1);
                if (!is_div(op_q))
                    prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
            end
            if (finish)
                result_q <= final_val;
        end
    end

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (step_en && is_div(op_q)),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quot     (quot),
        .rem      (rem)
    );

    assign bus.busy   = (state_q != IDLE);
    assign bus.valid  = (state_q == DONE);
    assign bus.result = result_q;

endmodule
